// File: rtl/schedule_1_pkg.sv
// Shared scheduler definitions: opcode7 classes, the bubble encoding and the
// registered instruction bundle carried between scheduler stages.
package schedule_1_pkg;

  localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [6:0]  OP_MISCMEM = 7'b0001111;
  localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;
  localparam logic [16:0] OPC_BUBBLE = 17'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [16:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] csr;
    logic [31:0] imm;
  } sched_instr_t;

  // True when the instruction architecturally writes a non-zero destination.
  function automatic logic writes_rd_f(input logic [16:0] opcode, input logic [4:0] rd);
    logic wr;
    case (opcode[6:0])
      OP_BRANCH, OP_STORE, OP_MISCMEM: wr = 1'b0;
      default:                         wr = (opcode != OPC_BUBBLE) && (rd != 5'd0);
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/schedule_1_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register plus a
// saturating outstanding-write counter; both see same-cycle writeback early.
module sched_scoreboard #(
  parameter int MAX_PENDING = 8,
  parameter int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          hold,
  input  logic          set_en,
  input  logic [4:0]    set_rd,
  input  logic          clr_en,
  input  logic [4:0]    clr_rd,
  output logic [31:0]   pend_eff,
  output logic [CW-1:0] count_eff
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_PENDING);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  logic [31:0]   sb_r;
  logic [CW-1:0] count_r;
  logic [31:0]   clr_mask_s;
  logic [31:0]   set_mask_s;
  logic [31:0]   sb_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic          clr_hit_s;
  logic          inc_s;

  assign clr_mask_s = clr_en ? (32'd1 << clr_rd) : 32'd0;
  assign inc_s      = set_en && (set_rd != 5'd0);
  assign set_mask_s = inc_s ? (32'd1 << set_rd) : 32'd0;
  assign clr_hit_s  = clr_en && sb_r[clr_rd];

  assign pend_eff  = sb_r & ~clr_mask_s;
  assign count_eff = clr_hit_s ? (count_r - ONE_C) : count_r;
  // Set is applied after clear so a same-register set wins; x0 never pends.
  assign sb_nxt_s  = ((sb_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

  // Next outstanding count, saturating at both ends.
  always_comb begin
    count_nxt_s = count_r;
    if (inc_s && !clr_hit_s) begin
      if (count_r != MAX_C) count_nxt_s = count_r + ONE_C;
      else                  count_nxt_s = count_r;
    end else if (!inc_s && clr_hit_s) begin
      if (count_r != ZERO_C) count_nxt_s = count_r - ONE_C;
      else                   count_nxt_s = count_r;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Scoreboard state register; flush outranks the freeze.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sb_r    <= 32'd0;
      count_r <= ZERO_C;
    end else if (flush) begin
      sb_r    <= 32'd0;
      count_r <= ZERO_C;
    end else if (hold) begin
      sb_r    <= sb_r;
      count_r <= count_r;
    end else begin
      sb_r    <= sb_nxt_s;
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/schedule_1.sv
// Scheduler stage 1: RAW/WAW/serialisation hazard detection against the
// pending-write scoreboard and the registered SCHEDULE_* issue bundle.
module schedule_1
  import schedule_1_pkg::*;
#(
  parameter int MAX_PENDING = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic [31:0] CHECK_PC,
  input  logic [16:0] CHECK_OPCODE,
  input  logic [4:0]  CHECK_RD,
  input  logic [4:0]  CHECK_RS1,
  input  logic [4:0]  CHECK_RS2,
  input  logic [11:0] CHECK_CSR,
  input  logic [31:0] CHECK_IMM,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
  output logic        STALL,
  output logic        SCHEDULE_VALID,
  output logic [31:0] SCHEDULE_PC,
  output logic [16:0] SCHEDULE_OPCODE,
  output logic [4:0]  SCHEDULE_RD,
  output logic [4:0]  SCHEDULE_RS1,
  output logic [4:0]  SCHEDULE_RS2,
  output logic [11:0] SCHEDULE_CSR,
  output logic [31:0] SCHEDULE_IMM
);

  localparam int            CW    = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PENDING);

  logic [31:0]   pend_eff_s;
  logic [CW-1:0] count_eff_s;
  logic          valid_in_s;
  logic          writes_rd_s;
  logic          hazard_s;
  logic          reg_haz_s;
  logic          sys_haz_s;
  logic          full_haz_s;
  sched_instr_t  instr_in_s;
  sched_instr_t  sched_nxt_s;
  sched_instr_t  sched_r;
  logic          valid_r;

  assign valid_in_s  = (CHECK_OPCODE != OPC_BUBBLE);
  assign writes_rd_s = writes_rd_f(CHECK_OPCODE, CHECK_RD);

  assign reg_haz_s  = ((CHECK_RS1 != 5'd0) && pend_eff_s[CHECK_RS1]) ||
                      ((CHECK_RS2 != 5'd0) && pend_eff_s[CHECK_RS2]) ||
                      (writes_rd_s && pend_eff_s[CHECK_RD]);
  assign sys_haz_s  = (CHECK_OPCODE[6:0] == OP_SYSTEM) && (count_eff_s != {CW{1'b0}});
  // Without a retiring write the count cannot drop, so a new writer must wait.
  assign full_haz_s = writes_rd_s && (count_eff_s == MAX_C) && !WB_VALID;
  assign hazard_s   = reg_haz_s || sys_haz_s || full_haz_s;

  assign STALL = valid_in_s && hazard_s && !FLUSH;

  sched_scoreboard #(
    .MAX_PENDING (MAX_PENDING),
    .CW          (CW)
  ) u_sb (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (FLUSH),
    .hold      (MEM_WAIT),
    .set_en    (writes_rd_s && !hazard_s),
    .set_rd    (CHECK_RD),
    .clr_en    (WB_VALID),
    .clr_rd    (WB_RD),
    .pend_eff  (pend_eff_s),
    .count_eff (count_eff_s)
  );

  assign instr_in_s = '{pc: CHECK_PC, opcode: CHECK_OPCODE, rd: CHECK_RD,
                        rs1: CHECK_RS1, rs2: CHECK_RS2, csr: CHECK_CSR,
                        imm: CHECK_IMM};

  // A hazarded slot becomes an all-zero bubble rather than a stale copy.
  always_comb begin
    sched_nxt_s = '0;
    if (hazard_s) sched_nxt_s = '0;
    else          sched_nxt_s = instr_in_s;
  end

  // Issue register into scheduler stage 2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sched_r <= '0;
      valid_r <= 1'b0;
    end else if (FLUSH) begin
      sched_r <= '0;
      valid_r <= 1'b0;
    end else if (MEM_WAIT) begin
      sched_r <= sched_r;
      valid_r <= valid_r;
    end else begin
      sched_r <= sched_nxt_s;
      valid_r <= valid_in_s && !hazard_s;
    end
  end

  assign SCHEDULE_VALID  = valid_r;
  assign SCHEDULE_PC     = sched_r.pc;
  assign SCHEDULE_OPCODE = sched_r.opcode;
  assign SCHEDULE_RD     = sched_r.rd;
  assign SCHEDULE_RS1    = sched_r.rs1;
  assign SCHEDULE_RS2    = sched_r.rs2;
  assign SCHEDULE_CSR    = sched_r.csr;
  assign SCHEDULE_IMM    = sched_r.imm;

endmodule
